axi_lite_regbank: RTL and testbench

//  Peripheral register file on the local user bus of the AXI-Lite slave: consumes user_wr_*/user_rd_*, returns rd data/resp.

---
 rtl/axi_lite_regbank_pkg.sv | 33 +++
 rtl/axi_lite_regbank_evt_sync_edge.sv | 30 +++
 rtl/axi_lite_regbank.sv | 157 +++++++++++++++
 tb/tb_axi_lite_regbank.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_regbank_pkg.sv
// Shared constants for the peripheral register bank: register offsets, bit indices and responses.
package axi_lite_regbank_pkg;

    localparam logic [4:0] OFF_CTRL       = 5'h00;
    localparam logic [4:0] OFF_STATUS     = 5'h04;
    localparam logic [4:0] OFF_IRQ_STATUS = 5'h08;
    localparam logic [4:0] OFF_IRQ_ENABLE = 5'h0C;
    localparam logic [4:0] OFF_SCRATCH    = 5'h10;
    localparam logic [4:0] OFF_COUNTER    = 5'h14;
    localparam logic [4:0] OFF_COMPARE    = 5'h18;
    localparam logic [4:0] OFF_VERSION    = 5'h1C;

    localparam int unsigned CTRL_CNT_EN     = 0;
    localparam int unsigned CTRL_CNT_CLR    = 1;
    localparam int unsigned STATUS_CNT_EN   = 0;
    localparam int unsigned STATUS_IRQ_PEND = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

    function automatic logic is_ro(input logic [4:0] off);
        return (off == OFF_STATUS) || (off == OFF_COUNTER) || (off == OFF_VERSION);
    endfunction

endpackage

// File: rtl/axi_lite_regbank_evt_sync_edge.sv
// Two-flop synchroniser per bit followed by a rising-edge detector.
module evt_sync_edge #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] async_i,
    output logic [Width-1:0] rise_o
);

    logic [Width-1:0] sync1_q;
    logic [Width-1:0] sync2_q;
    logic [Width-1:0] prev_q;

    // Zero reset means an input already high at reset exit yields one edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/axi_lite_regbank.sv
// Register bank behind the AXI-Lite user bus: control, scratch, IRQ and a compare timer.
module axi_lite_regbank
    import axi_lite_regbank_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           NUM_EVT    = 4,
    parameter logic [31:0]           VERSION    = 32'h0001_0000
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ADDR_WIDTH-1:0]   user_wr_addr,
    input  logic [DATA_WIDTH-1:0]   user_wr_data,
    input  logic [DATA_WIDTH/8-1:0] user_wr_strb,
    input  logic                    user_wr_en,
    output logic [1:0]              user_wr_resp,
    input  logic [ADDR_WIDTH-1:0]   user_rd_addr,
    input  logic                    user_rd_en,
    output logic [DATA_WIDTH-1:0]   user_rd_data,
    output logic [1:0]              user_rd_resp,
    input  logic [NUM_EVT-1:0]      evt_in,
    output logic                    ctrl_cnt_en,
    output logic                    irq
);

    logic              cnt_en_q, cnt_en_d;
    logic [NUM_EVT:0]  irq_status_q, irq_status_d;
    logic [NUM_EVT:0]  irq_enable_q, irq_enable_d;
    logic [31:0]       scratch_q, scratch_d;
    logic [31:0]       counter_q, counter_d;
    logic [31:0]       compare_q, compare_d;
    logic              irq_q;
    logic [31:0]       rd_data_q, rd_data_d;
    logic [1:0]        rd_resp_q, rd_resp_d;

    logic [NUM_EVT-1:0] evt_rise;
    logic               irq_pending;
    logic               timer_match;
    logic               wr_valid_addr, rd_valid_addr, wr_ok, cnt_clr;
    logic [4:0]         wr_off, rd_off;
    logic [31:0]        wmask, wdata_m;
    logic [NUM_EVT:0]   w1c;

    evt_sync_edge #(
        .Width (NUM_EVT)
    ) u_evt_sync (
        .clk_i   (aclk),
        .rst_ni  (aresetn),
        .async_i (evt_in),
        .rise_o  (evt_rise)
    );

    // The window is 32-byte aligned, so the upper address bits identify it.
    assign wr_off        = user_wr_addr[4:0];
    assign rd_off        = user_rd_addr[4:0];
    assign wr_valid_addr = (user_wr_addr[1:0] == 2'b00) &&
                           (user_wr_addr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]);
    assign rd_valid_addr = (user_rd_addr[1:0] == 2'b00) &&
                           (user_rd_addr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]);
    assign user_wr_resp  = (wr_valid_addr && !is_ro(wr_off)) ? RESP_OKAY : RESP_SLVERR;
    assign wr_ok         = user_wr_en && (user_wr_resp == RESP_OKAY);

    assign wmask       = strb_mask(user_wr_strb);
    assign wdata_m     = user_wr_data & wmask;
    assign irq_pending = |(irq_status_q & irq_enable_q);
    assign timer_match = cnt_en_q && (counter_q == compare_q);

    always_comb begin
        cnt_en_d     = cnt_en_q;
        cnt_clr      = 1'b0;
        irq_enable_d = irq_enable_q;
        scratch_d    = scratch_q;
        compare_d    = compare_q;
        w1c          = '0;
        if (wr_ok) begin
            case (wr_off)
                OFF_CTRL: begin
                    if (user_wr_strb[0]) begin
                        cnt_en_d = user_wr_data[CTRL_CNT_EN];
                        cnt_clr  = user_wr_data[CTRL_CNT_CLR];
                    end
                end
                OFF_IRQ_STATUS: w1c = wdata_m[NUM_EVT:0];
                OFF_IRQ_ENABLE: irq_enable_d = (irq_enable_q & ~wmask[NUM_EVT:0]) |
                                               wdata_m[NUM_EVT:0];
                OFF_SCRATCH:    scratch_d = (scratch_q & ~wmask) | wdata_m;
                OFF_COMPARE:    compare_d = (compare_q & ~wmask) | wdata_m;
                default: ;
            endcase
        end
        // New events are ORed in after the clear so a set always wins.
        irq_status_d = (irq_status_q & ~w1c) | {timer_match, evt_rise};
        if (cnt_clr) begin
            counter_d = '0;
        end else if (cnt_en_q) begin
            counter_d = counter_q + 32'd1;
        end else begin
            counter_d = counter_q;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        rd_resp_d = rd_resp_q;
        if (user_rd_en) begin
            rd_data_d = '0;
            rd_resp_d = rd_valid_addr ? RESP_OKAY : RESP_SLVERR;
            if (rd_valid_addr) begin
                case (rd_off)
                    OFF_CTRL:       rd_data_d[CTRL_CNT_EN] = cnt_en_q;
                    OFF_STATUS: begin
                        rd_data_d[STATUS_CNT_EN]   = cnt_en_q;
                        rd_data_d[STATUS_IRQ_PEND] = irq_pending;
                    end
                    OFF_IRQ_STATUS: rd_data_d[NUM_EVT:0] = irq_status_q;
                    OFF_IRQ_ENABLE: rd_data_d[NUM_EVT:0] = irq_enable_q;
                    OFF_SCRATCH:    rd_data_d = scratch_q;
                    OFF_COUNTER:    rd_data_d = counter_q;
                    OFF_COMPARE:    rd_data_d = compare_q;
                    OFF_VERSION:    rd_data_d = VERSION;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_en_q     <= 1'b0;
            irq_status_q <= '0;
            irq_enable_q <= '0;
            scratch_q    <= '0;
            counter_q    <= '0;
            compare_q    <= 32'hFFFF_FFFF;
            irq_q        <= 1'b0;
            rd_data_q    <= '0;
            rd_resp_q    <= RESP_OKAY;
        end else begin
            cnt_en_q     <= cnt_en_d;
            irq_status_q <= irq_status_d;
            irq_enable_q <= irq_enable_d;
            scratch_q    <= scratch_d;
            counter_q    <= counter_d;
            compare_q    <= compare_d;
            irq_q        <= irq_pending;
            rd_data_q    <= rd_data_d;
            rd_resp_q    <= rd_resp_d;
        end
    end

    assign user_rd_data = rd_data_q;
    assign user_rd_resp = rd_resp_q;
    assign ctrl_cnt_en  = cnt_en_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed bench for axi_lite_regbank: decode, strobes, events, timer, IRQ and async reset.
module tb_axi_lite_regbank;

    logic        aclk;
    logic        aresetn;
    logic [31:0] user_wr_addr;
    logic [31:0] user_wr_data;
    logic [3:0]  user_wr_strb;
    logic        user_wr_en;
    logic [1:0]  user_wr_resp;
    logic [31:0] user_rd_addr;
    logic        user_rd_en;
    logic [31:0] user_rd_data;
    logic [1:0]  user_rd_resp;
    logic [3:0]  evt_in;
    logic        ctrl_cnt_en;
    logic        irq;

    int tests = 0;
    int fails = 0;

    axi_lite_regbank dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .user_wr_addr (user_wr_addr),
        .user_wr_data (user_wr_data),
        .user_wr_strb (user_wr_strb),
        .user_wr_en   (user_wr_en),
        .user_wr_resp (user_wr_resp),
        .user_rd_addr (user_rd_addr),
        .user_rd_en   (user_rd_en),
        .user_rd_data (user_rd_data),
        .user_rd_resp (user_rd_resp),
        .evt_in       (evt_in),
        .ctrl_cnt_en  (ctrl_cnt_en),
        .irq          (irq)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] exp_resp, input string tag);
        user_wr_addr = a;
        user_wr_data = d;
        user_wr_strb = s;
        user_wr_en   = 1'b1;
        #1 check(tag, {30'd0, user_wr_resp}, {30'd0, exp_resp});
        @(negedge aclk);
        user_wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input string tag);
        user_rd_addr = a;
        user_rd_en   = 1'b1;
        @(negedge aclk);
        user_rd_en = 1'b0;
        check({tag, ".data"}, user_rd_data, exp_data);
        check({tag, ".resp"}, {30'd0, user_rd_resp}, {30'd0, exp_resp});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge aclk);
    endtask

    initial begin
        aresetn      = 1'b0;
        user_wr_addr = '0;
        user_wr_data = '0;
        user_wr_strb = '0;
        user_wr_en   = 1'b0;
        user_rd_addr = '0;
        user_rd_en   = 1'b0;
        evt_in       = '0;
        idle(2);
        check("rst.rd_data", user_rd_data, 32'h0);
        check("rst.rd_resp", {30'd0, user_rd_resp}, 32'h0);
        check("rst.irq", {31'd0, irq}, 32'h0);
        check("rst.cnt_en", {31'd0, ctrl_cnt_en}, 32'h0);
        aresetn = 1'b1;
        idle(1);
        do_read(32'h18, 32'hFFFF_FFFF, 2'b00, "rst.compare");
        do_read(32'h14, 32'h0, 2'b00, "rst.counter");

        // Byte strobes on SCRATCH, then latency and hold of read data
        do_write(32'h10, 32'hDEAD_BEEF, 4'b0101, 2'b00, "scr.wr_resp");
        do_read(32'h10, 32'h00AD_00EF, 2'b00, "scr.rd");
        idle(2);
        check("scr.hold", user_rd_data, 32'h00AD_00EF);

        // Decode errors
        do_read(32'h20, 32'h0, 2'b10, "err.rd_oob");
        do_read(32'h02, 32'h0, 2'b10, "err.rd_misalign");
        do_write(32'h1C, 32'h1234_5678, 4'hF, 2'b10, "err.wr_version");
        do_write(32'h12, 32'h1234_5678, 4'hF, 2'b10, "err.wr_misalign");
        do_read(32'h1C, 32'h0001_0000, 2'b00, "err.version");
        do_read(32'h10, 32'h00AD_00EF, 2'b00, "err.scr_untouched");

        // Read and write of the same register in one cycle returns the old value
        user_wr_addr = 32'h10;
        user_wr_data = 32'hFFFF_FFFF;
        user_wr_strb = 4'hF;
        user_wr_en   = 1'b1;
        user_rd_addr = 32'h10;
        user_rd_en   = 1'b1;
        @(negedge aclk);
        user_wr_en = 1'b0;
        user_rd_en = 1'b0;
        check("rw.old", user_rd_data, 32'h00AD_00EF);
        do_read(32'h10, 32'hFFFF_FFFF, 2'b00, "rw.new");

        // Event 0 -> IRQ_STATUS after 3 edges, irq one edge later, W1C drops it
        do_write(32'h0C, 32'h1, 4'hF, 2'b00, "irq.en_wr");
        evt_in[0] = 1'b1;
        idle(3);
        check("irq.not_yet", {31'd0, irq}, 32'h0);
        idle(1);
        check("irq.set", {31'd0, irq}, 32'h1);
        do_read(32'h08, 32'h1, 2'b00, "irq.status");
        do_read(32'h04, 32'h2, 2'b00, "irq.status_reg");
        evt_in[0] = 1'b0;
        do_write(32'h08, 32'h1, 4'hF, 2'b00, "irq.w1c_wr");
        check("irq.still", {31'd0, irq}, 32'h1);
        idle(1);
        check("irq.clr", {31'd0, irq}, 32'h0);
        do_read(32'h08, 32'h0, 2'b00, "irq.status_clr");

        // Timer: counter starts the edge after CTRL write, match sets bit 4
        do_write(32'h18, 32'd10, 4'hF, 2'b00, "tmr.cmp_wr");
        do_write(32'h00, 32'h1, 4'hF, 2'b00, "tmr.ctrl_wr");
        check("tmr.cnt_en", {31'd0, ctrl_cnt_en}, 32'h1);
        idle(3);
        do_read(32'h14, 32'd3, 2'b00, "tmr.counter");
        idle(15);
        do_read(32'h08, 32'h10, 2'b00, "tmr.match");
        check("tmr.irq_masked", {31'd0, irq}, 32'h0);
        do_write(32'h00, 32'h3, 4'hF, 2'b00, "tmr.clr_wr");
        do_read(32'h14, 32'd0, 2'b00, "tmr.cleared");
        do_read(32'h00, 32'h1, 2'b00, "tmr.ctrl_rd");
        do_write(32'h00, 32'h0, 4'hF, 2'b00, "tmr.stop_wr");
        do_write(32'h08, 32'h10, 4'hF, 2'b00, "tmr.w1c_wr");
        do_read(32'h14, 32'd3, 2'b00, "tmr.stopped");
        do_read(32'h08, 32'h0, 2'b00, "tmr.status_clr");

        // Event 1 edge coinciding with W1C of bit 1: set wins
        evt_in[1] = 1'b1;
        idle(4);
        evt_in[1] = 1'b0;
        idle(3);
        do_read(32'h08, 32'h2, 2'b00, "sw.pre");
        evt_in[1] = 1'b1;
        idle(2);
        do_write(32'h08, 32'h2, 4'hF, 2'b00, "sw.w1c_wr");
        do_read(32'h08, 32'h2, 2'b00, "sw.set_wins");
        do_write(32'h08, 32'h2, 4'hF, 2'b00, "sw.w1c2_wr");
        do_read(32'h08, 32'h0, 2'b00, "sw.cleared");
        evt_in[1] = 1'b0;

        // Asynchronous reset mid-count with irq high
        do_write(32'h0C, 32'h1F, 4'hF, 2'b00, "ar.en_wr");
        do_write(32'h00, 32'h1, 4'hF, 2'b00, "ar.ctrl_wr");
        evt_in[0] = 1'b1;
        idle(4);
        check("ar.irq_hi", {31'd0, irq}, 32'h1);
        do_read(32'h1C, 32'h0001_0000, 2'b00, "ar.version");
        #2 aresetn = 1'b0;
        evt_in = '0;
        #1;
        check("ar.irq", {31'd0, irq}, 32'h0);
        check("ar.cnt_en", {31'd0, ctrl_cnt_en}, 32'h0);
        check("ar.rd_data", user_rd_data, 32'h0);
        @(negedge aclk);
        aresetn = 1'b1;
        do_read(32'h14, 32'h0, 2'b00, "ar.counter");
        do_read(32'h18, 32'hFFFF_FFFF, 2'b00, "ar.compare");
        do_read(32'h08, 32'h0, 2'b00, "ar.status");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
